// File: rtl/requant_pkg.sv
// ============================================================================
//  Module   : requant_pkg
//  Purpose  : Shared types and helpers for the requantization parameter
//             ROM arbiter (FSM state encoding, index-width helper).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package requant_pkg;

  // Arbiter transaction states; READ drives the ROM, WAIT captures its data.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } requant_arb_state_t;

  // Width of an index into n entries, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : requant_pkg

`default_nettype wire

// File: rtl/requant_param_arbiter_rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin picker. Returns the first asserted
//             request at or after the priority pointer (wrapping) as a
//             one-hot grant plus its binary index.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_pos;
  logic          w_found;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_pos   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_pos = IW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
    o_any = w_found;
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/requant_param_arbiter.sv
// ============================================================================
//  Module   : requant_param_arbiter
//  Purpose  : Shares the single-port requantization scale ROM among several
//             requesters. Round-robin accept in IDLE, one ROM read in
//             flight, response held on a valid/ready handshake. Layer
//             indices beyond the ROM depth are answered with an error and
//             zeroed data without touching the ROM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module requant_param_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int NUM_LAYERS  = 6,
  parameter  int MULT_WIDTH  = 32,
  parameter  int SHIFT_WIDTH = 6,
  localparam int LIDX_W      = requant_pkg::idx_width(NUM_LAYERS),
  localparam int RIDX_W      = requant_pkg::idx_width(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][LIDX_W-1:0]      req_layer,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic signed [MULT_WIDTH-1:0]        rsp_mult,
  output logic signed [SHIFT_WIDTH-1:0]       rsp_shift,
  output logic                                rsp_err,
  output logic                                rom_valid,
  output logic [LIDX_W-1:0]                   rom_layer_idx,
  input  logic [MULT_WIDTH-1:0]               rom_mult_in,
  input  logic [SHIFT_WIDTH-1:0]              rom_shift_in,
  output logic                                busy
);

  import requant_pkg::*;

  requant_arb_state_t r_state;
  requant_arb_state_t w_state_nxt;

  logic [RIDX_W-1:0]            r_rr_ptr;
  logic [RIDX_W-1:0]            r_grant_idx;
  logic                         r_rom_valid;
  logic [LIDX_W-1:0]            r_rom_idx;
  logic signed [MULT_WIDTH-1:0] r_rsp_mult;
  logic signed [SHIFT_WIDTH-1:0] r_rsp_shift;
  logic                         r_rsp_err;

  logic [NUM_REQ-1:0]           w_win_onehot;
  logic [RIDX_W-1:0]            w_win_idx;
  logic                         w_win_any;
  logic [LIDX_W-1:0]            w_win_layer;
  logic                         w_win_in_range;
  logic                         w_accept;
  logic [RIDX_W-1:0]            w_ptr_nxt;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (RIDX_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_win_onehot),
    .o_idx   (w_win_idx),
    .o_any   (w_win_any)
  );

  // Decode the winning request: its layer, range check and next pointer.
  always_comb begin
    w_win_layer    = req_layer[w_win_idx];
    w_win_in_range = (int'(w_win_layer) < NUM_LAYERS);
    w_accept       = (r_state == IDLE) && w_win_any;
    w_ptr_nxt      = w_win_idx + RIDX_W'(1);
    if (int'(w_win_idx) == NUM_REQ - 1) begin
      w_ptr_nxt = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; bad layer indices skip the ROM entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_win_any) begin
          w_state_nxt = w_win_in_range ? READ : RESP;
        end
      end
      READ:    w_state_nxt = WAIT;
      WAIT:    w_state_nxt = RESP;
      RESP: begin
        if (rsp_ready[r_grant_idx]) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (r_state == IDLE) begin
      req_ready = w_win_onehot;
    end
    if (r_state == RESP) begin
      rsp_valid[r_grant_idx] = 1'b1;
    end
    busy = (r_state != IDLE);
  end

  // Grant/pointer bookkeeping, ROM request and response capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_rom_valid <= 1'b0;
      r_rom_idx   <= '0;
      r_rsp_mult  <= '0;
      r_rsp_shift <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // One-cycle ROM strobe, only for in-range accepts.
      r_rom_valid <= w_accept && w_win_in_range;
      if (w_accept) begin
        r_grant_idx <= w_win_idx;
        r_rr_ptr    <= w_ptr_nxt;
        r_rsp_err   <= !w_win_in_range;
        if (w_win_in_range) begin
          r_rom_idx <= w_win_layer;
        end else begin
          r_rsp_mult  <= '0;
          r_rsp_shift <= '0;
        end
      end
      // ROM data arrives the cycle after the strobe; pass it through untouched.
      if (r_state == WAIT) begin
        r_rsp_mult  <= rom_mult_in;
        r_rsp_shift <= rom_shift_in;
      end
    end
  end

  assign rom_valid     = r_rom_valid;
  assign rom_layer_idx = r_rom_idx;
  assign rsp_mult      = r_rsp_mult;
  assign rsp_shift     = r_rsp_shift;
  assign rsp_err       = r_rsp_err;

endmodule : requant_param_arbiter

`default_nettype wire

// File: tb/tb_requant_param_arbiter.sv
// ============================================================================
//  Module   : tb_requant_param_arbiter
//  Purpose  : Self-checking bench for requant_param_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_requant_param_arbiter;

  localparam int NR = 4;
  localparam int NL = 6;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       req_valid = '0;
  logic [3:0][2:0]  req_layer = '0;
  logic [3:0]       req_ready;
  logic [3:0]       rsp_valid;
  logic [3:0]       rsp_ready = '0;
  logic signed [31:0] rsp_mult;
  logic signed [5:0]  rsp_shift;
  logic             rsp_err;
  logic             rom_valid;
  logic [2:0]       rom_layer_idx;
  logic [31:0]      rom_mult_in = '0;
  logic [5:0]       rom_shift_in = '0;
  logic             busy;

  requant_param_arbiter #(
    .NUM_REQ(NR), .NUM_LAYERS(NL), .MULT_WIDTH(32), .SHIFT_WIDTH(6)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_layer(req_layer), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_mult(rsp_mult), .rsp_shift(rsp_shift), .rsp_err(rsp_err),
    .rom_valid(rom_valid), .rom_layer_idx(rom_layer_idx),
    .rom_mult_in(rom_mult_in), .rom_shift_in(rom_shift_in),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ROM model: entries 6/7 hold junk so a stray out-of-range read is visible.
  logic [31:0] rom_m [0:7];
  logic [5:0]  rom_s [0:7];

  always @(posedge clk) begin
    if (rom_valid) begin
      rom_mult_in  <= rom_m[rom_layer_idx];
      rom_shift_in <= rom_s[rom_layer_idx];
    end
  end

  typedef struct {
    int          id;
    logic [31:0] mult;
    logic [5:0]  shift;
    logic        err;
    int          lat;
    int          t_acc;
  } exp_t;

  typedef struct {
    int         id;
    logic [2:0] layer;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;
  int   cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'd1;
    return one << i;
  endfunction

  function automatic int pick(input logic [3:0] m);
    for (int k = 0; k < NR; k++) begin
      if (m[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called in the accept cycle: checks req_ready and records the expected response.
  task automatic accept_push(input logic [3:0] mask, input logic exp_err, input int exp_lat);
    int   g;
    exp_t e;
    g = pick(mask);
    chk("req_ready", req_ready, oh(g));
    e.id    = g;
    e.err   = exp_err;
    e.mult  = exp_err ? 32'd0 : rom_m[req_layer[g]];
    e.shift = exp_err ? 6'd0  : rom_s[req_layer[g]];
    e.lat   = exp_lat;
    e.t_acc = cyc;
    sb.push_back(e);
    m_ptr = (g + 1) % NR;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got rsp_valid %0h expected none", rsp_valid);
    end else begin
      e = sb.pop_front();
      chk("rsp_valid", rsp_valid, oh(e.id));
      chk("rsp_mult", {rsp_mult}, e.mult);
      chk("rsp_shift", {rsp_shift}, e.shift);
      chk("rsp_err", rsp_err, e.err);
      chk("rsp_latency", cyc - e.t_acc, e.lat);
    end
  endtask

  task automatic wait_and_check();
    int n;
    n = 0;
    while (rsp_valid == 4'd0 && n < 12) begin
      tick();
      n++;
    end
    if (n >= 12) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 12 cycles");
    end else begin
      pop_check();
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 4'hF;
    sb.delete();
    m_ptr = 0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rom_m[0] = 32'h0000_7FFF; rom_s[0] = 6'd5;
    rom_m[1] = 32'h8000_0000; rom_s[1] = 6'h20;
    rom_m[2] = 32'h4000_0001; rom_s[2] = 6'h37;
    rom_m[3] = 32'hFFFF_FFFF; rom_s[3] = 6'd31;
    rom_m[4] = 32'h1234_5678; rom_s[4] = 6'h3F;
    rom_m[5] = 32'h7FFF_FFFF; rom_s[5] = 6'd12;
    rom_m[6] = 32'hDEAD_BEEF; rom_s[6] = 6'h2A;
    rom_m[7] = 32'hCAFE_F00D; rom_s[7] = 6'h15;

    tbl[0] = '{0, 3'd2, 1'b0, 3};
    tbl[1] = '{1, 3'd0, 1'b0, 3};
    tbl[2] = '{2, 3'd5, 1'b0, 3};
    tbl[3] = '{3, 3'd7, 1'b1, 1};
    tbl[4] = '{1, 3'd6, 1'b1, 1};
    tbl[5] = '{0, 3'd3, 1'b0, 3};
    tbl[6] = '{3, 3'd1, 1'b0, 3};
    tbl[7] = '{2, 3'd4, 1'b0, 3};

    // Reset values.
    do_reset();
    chk("reset_busy", busy, 1'b0);
    chk("reset_rom_valid", rom_valid, 1'b0);
    chk("reset_rom_idx", rom_layer_idx, 3'd0);
    chk("reset_rsp_valid", rsp_valid, 4'd0);
    chk("reset_rsp_mult", {rsp_mult}, 32'd0);
    chk("reset_rsp_shift", {rsp_shift}, 6'd0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_req_ready", req_ready, 4'd0);

    // Table of single-requester transactions.
    for (int i = 0; i < 8; i++) begin
      req_layer = '0;
      req_layer[tbl[i].id] = tbl[i].layer;
      req_valid = oh(tbl[i].id);
      rsp_ready = 4'hF;
      #1;
      chk("idle_busy", busy, 1'b0);
      accept_push(req_valid, tbl[i].exp_err, tbl[i].exp_lat);
      tick();
      req_valid = '0;
      chk("rom_valid_t1", rom_valid, !tbl[i].exp_err);
      if (!tbl[i].exp_err) chk("rom_idx_t1", rom_layer_idx, tbl[i].layer);
      wait_and_check();
      tick();
      chk("rsp_valid_clear", rsp_valid, 4'd0);
    end

    // All four requesting with rsp_ready held: order 0,1,2,3,0, four cycles apart.
    do_reset();
    req_layer[0] = 3'd1; req_layer[1] = 3'd2; req_layer[2] = 3'd3; req_layer[3] = 3'd4;
    req_valid = 4'hF;
    #1;
    begin
      int last_acc;
      int n_acc;
      last_acc = -4;
      n_acc = 0;
      for (int c = 0; c < 20; c++) begin
        chk("rr_ready_vs_busy", req_ready != 4'd0, !busy);
        if (req_ready != 4'd0) begin
          chk("rr_spacing", c - last_acc, 4);
          last_acc = c;
          n_acc++;
          accept_push(req_valid, 1'b0, 3);
        end
        if (rsp_valid != 4'd0) pop_check();
        if (c == 19) req_valid = '0;
        tick();
      end
      chk("rr_accept_count", n_acc, 5);
    end
    chk("rr_idle_after", busy, 1'b0);
    chk("rr_sb_drained", sb.size(), 0);

    // Backpressure with competing requests and a stray rsp_ready on other bits.
    req_layer = '0;
    req_layer[1] = 3'd4;
    req_valid = 4'b0010;
    rsp_ready = 4'd0;
    #1;
    accept_push(req_valid, 1'b0, 3);
    tick();
    req_valid = 4'b1101;
    wait_and_check();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_rsp_mult", {rsp_mult}, rom_m[4]);
      chk("bp_rsp_shift", {rsp_shift}, rom_s[4]);
      chk("bp_req_ready", req_ready, 4'd0);
      chk("bp_busy", busy, 1'b1);
    end
    rsp_ready = 4'b0101;
    tick();
    chk("wrong_ready_ignored", rsp_valid, 4'b0010);
    req_valid = '0;
    rsp_ready = 4'b0010;
    tick();
    chk("bp_done_valid", rsp_valid, 4'd0);
    chk("bp_done_busy", busy, 1'b0);
    chk("idle_hold_mult", {rsp_mult}, rom_m[4]);
    chk("idle_hold_shift", {rsp_shift}, rom_s[4]);
    rsp_ready = 4'hF;

    // Reset asserted while the ROM read is in WAIT aborts the transaction.
    req_layer = '0;
    req_layer[2] = 3'd3;
    req_valid = 4'b0100;
    #1;
    accept_push(req_valid, 1'b0, 3);
    tick();
    req_valid = '0;
    tick();
    chk("pre_reset_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_rom_valid", rom_valid, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 4'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp_mult", {rsp_mult}, 32'd0);
    chk("abort_rsp_err", rsp_err, 1'b0);
    chk("abort_rom_idx", rom_layer_idx, 3'd0);
    sb.delete();
    m_ptr = 0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_rsp_after_abort", rsp_valid, 4'd0);
    end
    req_layer[0] = 3'd5; req_layer[1] = 3'd0; req_layer[2] = 3'd1; req_layer[3] = 3'd2;
    req_valid = 4'hF;
    #1;
    accept_push(req_valid, 1'b0, 3);
    tick();
    req_valid = '0;
    wait_and_check();
    tick();
    chk("final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_requant_param_arbiter

`default_nettype wire
